// File: rtl/pc_unit_if.sv
// Request/response bundle between fetch control and the program-counter unit.
// master drives redirect requests; slave (pc_unit) returns PC and status.
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             branch_valid;
    logic [WIDTH-1:0] branch_target;
    logic             jump_valid;
    logic [WIDTH-1:0] jump_target;
    logic             call;
    logic             ret;
    logic             trap;
    logic             eret;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] epc;
    logic             in_trap;
    logic             ras_empty;
    logic             ras_full;
    logic             misalign;

    modport master (
        output stall, branch_valid, branch_target, jump_valid, jump_target,
               call, ret, trap, eret,
        input  pc, pc_plus, epc, in_trap, ras_empty, ras_full, misalign
    );

    modport slave (
        input  stall, branch_valid, branch_target, jump_valid, jump_target,
               call, ret, trap, eret,
        output pc, pc_plus, epc, in_trap, ras_empty, ras_full, misalign
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch PC register with prioritised next-PC selection, trap/eret and a
// circular return-address stack (compiled in when PC_UNIT_RAS_EN is defined).
module pc_unit #(
    parameter int          WIDTH     = 32,
    parameter int unsigned RESET_VEC = 0,
    parameter int unsigned TRAP_VEC  = 32'h0000_0080,
    parameter int unsigned STEP      = 4,
    parameter int          RAS_DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    pc_unit_if.slave bus
);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] TRAP_W  = WIDTH'(TRAP_VEC);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);

    localparam logic [0:0] ST_NORMAL = 1'b0;
    localparam logic [0:0] ST_TRAP   = 1'b1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [0:0]       st_q, st_d;
    logic [WIDTH-1:0] pc_plus;
    logic             trap_take, eret_take;

    assign pc_plus   = pc_q + STEP_W;
    assign trap_take = bus.trap && (st_q == ST_NORMAL);
    assign eret_take = bus.eret && (st_q == ST_TRAP);

`ifdef PC_UNIT_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push, pop;
    logic             ras_empty, ras_full;
    logic [WIDTH-1:0] ras_top;

    // ptr_q is the next write slot; the newest entry sits just below it.
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CW'(RAS_DEPTH));
    assign ras_top   = ras_mem[ptr_q - PW'(1)];
`else
    logic unused_call;
    assign unused_call = bus.call;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the priority chain so no path can infer a latch.
        pc_d  = pc_q;
        epc_d = epc_q;
        st_d  = st_q;
`ifdef PC_UNIT_RAS_EN
        push  = 1'b0;
        pop   = 1'b0;
`endif
        if (trap_take) begin
            epc_d = pc_q;
            pc_d  = TRAP_W;
            st_d  = ST_TRAP;
        end else if (eret_take) begin
            pc_d = epc_q;
            st_d = ST_NORMAL;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (bus.ret) begin
`ifdef PC_UNIT_RAS_EN
            if (!ras_empty) begin
                pc_d = ras_top;
                pop  = 1'b1;
            end else begin
                pc_d = bus.jump_target;
            end
`else
            pc_d = bus.jump_target;
`endif
        end else if (bus.jump_valid) begin
            pc_d = bus.jump_target;
`ifdef PC_UNIT_RAS_EN
            push = bus.call;
`endif
        end else if (bus.branch_valid) begin
            pc_d = bus.branch_target;
        end else begin
            pc_d = pc_plus;
        end

`ifdef PC_UNIT_RAS_EN
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (pop) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end else if (push) begin
            // A full stack overwrites its oldest slot, so the count saturates.
            ptr_d = ptr_q + PW'(1);
            if (!ras_full) cnt_d = cnt_q + CW'(1);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            pc_q  <= RESET_W;
            epc_q <= '0;
            st_q  <= ST_NORMAL;
`ifdef PC_UNIT_RAS_EN
            ptr_q <= '0;
            cnt_q <= '0;
`endif
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            st_q  <= st_d;
`ifdef PC_UNIT_RAS_EN
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
`endif
        end
    end

`ifdef PC_UNIT_RAS_EN
    // NOTE: stack storage is not reset; cnt_q guarantees no slot is read before it is written.
    always_ff @(posedge clk) begin
        if (push) ras_mem[ptr_q] <= pc_plus;
    end

    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
`else
    assign bus.ras_empty = 1'b1;
    assign bus.ras_full  = 1'b0;
`endif

    assign bus.pc       = pc_q;
    assign bus.pc_plus  = pc_plus;
    assign bus.epc      = epc_q;
    assign bus.in_trap  = (st_q == ST_TRAP);
    assign bus.misalign = |pc_q[1:0];
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the mips core; successor to the fixed +4 PC register/adder pair.
- Holds the fetch PC and computes next-PC with:
  - stall;
  - branch, jump, call and return redirects;
  - trap entry and exception return;
  - a small return-address stack (RAS).
- Sits at the head of fetch. Outputs pc to instruction memory and pc_plus to the decode/link path.

Parameters:
WIDTH, 32, PC/address width in bits (>=8)
RESET_VEC, 0, PC value loaded on reset
TRAP_VEC, 32'h00000080, PC loaded on trap entry (truncated to WIDTH)
STEP, 4, sequential increment in bytes
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  hold PC and RAS this cycle
branch_valid  in  1  taken branch redirect
branch_target  in  WIDTH  branch destination
jump_valid  in  1  jump redirect
jump_target  in  WIDTH  jump destination
call  in  1  qualifies jump_valid: push pc+STEP onto RAS
ret  in  1  return: pop RAS into PC
trap  in  1  exception request
eret  in  1  exception return
pc  out  WIDTH  current fetch PC (registered)
pc_plus  out  WIDTH  pc+STEP (combinational)
epc  out  WIDTH  saved exception PC (registered)
in_trap  out  1  FSM in TRAP state
ras_empty  out  1  RAS count==0
ras_full  out  1  RAS count==RAS_DEPTH
misalign  out  1  pc[1:0]!=0 (combinational from pc)

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_VEC, epc=0, FSM=NORMAL, in_trap=0.
  - RAS count=0, so ras_empty=1 and ras_full=0.
  - Released synchronously: first update on the first rising clk with reset=1.
- Single-cycle latency: every redirect is visible on pc the cycle after the request edge.
- Arithmetic is modulo 2^WIDTH. pc=all-ones-minus-(STEP-1) wraps to 0 on a sequential step.
- Next-PC priority, highest first:
  - trap: if NORMAL, then epc<=pc, pc<=TRAP_VEC, FSM->TRAP. If already in TRAP, the trap is ignored: no nested traps, pc/epc unchanged, evaluation continues down the list.
  - eret: if TRAP, then pc<=epc, FSM->NORMAL. If in NORMAL, ignored.
  - stall: pc, epc and RAS all hold. All lower-priority redirects are dropped; the requester must re-assert them.
  - ret:
    - RAS non-empty: pc<=top entry, count-1.
    - RAS empty: pc<=jump_target, count stays 0.
    - ret with call the same cycle: ret wins and call is ignored.
  - jump_valid: pc<=jump_target. If call=1, also push pc+STEP.
  - branch_valid: pc<=branch_target.
  - Otherwise: pc<=pc+STEP.
- Trap and eret override stall. RAS is untouched on trap and eret.
- RAS is circular:
  - A push when full overwrites the oldest entry; count stays RAS_DEPTH.
  - A pop after overflow returns the newest RAS_DEPTH addresses in LIFO order.
- call without jump_valid is ignored.
- FSM has 2 states, NORMAL and TRAP; in_trap=1 exactly in TRAP.

Optional Feature:
- Macro PC_UNIT_RAS_EN.
- Defined: RAS implemented as described above.
- Undefined:
  - No RAS storage.
  - ret behaves as a jump to jump_target.
  - call is ignored.
  - ras_empty tied to 1, ras_full tied to 0.
  - All other behaviour identical.

Test Plan:
- Reset and sequential fetch: reset=0 for 2 cycles, then released, 3 clocks, no requests -> pc 0, 4, 8, 0xC; mid-run reset=0 gives pc=0 immediately, without waiting for clk.
- Stall vs redirect: pc=0x10, stall=1 with branch_valid=1, branch_target=0x100 -> pc stays 0x10; next cycle stall=0, branch held -> pc=0x100.
- Trap/eret (hold stall=1 through this scenario):
  - pc=0x40, trap=1 -> pc=0x80, epc=0x40, in_trap=1.
  - Second trap -> ignored; pc stays 0x80 under the held stall.
  - eret -> pc=0x40, in_trap=0.
- Call/return: jump_valid=1, call=1, jump_target=0x200 at pc=0x20 -> pc=0x200, ras_empty=0; later ret=1 -> pc=0x24, ras_empty=1.
- RAS overflow (RAS_DEPTH=4): 5 calls from pcs A..E -> ras_full=1; 4 rets -> return addresses E+4, D+4, C+4, B+4; 5th ret with jump_target=0x300 -> pc=0x300.
- Wrap and misalign (WIDTH=8): pc=0xFC step -> pc=0x00. Branch to 0x05 -> misalign=1.
